aes_round_ctrl: RTL
===================

# aes_round_ctrl

Sequencing FSM for the iterative AES core that executes one transform per clock. It accepts a start request and then drives the shared round datapath through the full cipher: the initial AddRoundKey, then each round's SubBytes, ShiftRows, MixColumns and AddRoundKey steps, skipping MixColumns in the last round. It produces the operation select, the ShiftRows/SubBytes `inverse` control, the state-register load enable and the round-key index. It also signals completion with a one-cycle pulse.

## Interface
- `NR`, default 10: number of rounds; legal values 10, 12, 14.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start_i` in 1: request to begin a block; sampled only in IDLE.
- `decrypt_i` in 1: direction, sampled with `start_i`; 1 = inverse cipher.
- `ld_input_o` out 1: load plaintext/ciphertext into the state register; combinational `start_i & idle`.
- `ld_state_o` out 1: state register captures the datapath output this cycle.
- `op_o` out 2: datapath mux select; 0 ADDKEY, 1 SUB, 2 SHIFT, 3 MIX.
- `inverse_o` out 1: drives the datapath `inverse` inputs; equals the latched direction.
- `round_o` out 4: round-key index used by ADDKEY, in the range 0..NR.
- `busy_o` out 1: high from the cycle after acceptance through the last op cycle.
- `done_o` out 1: one-cycle pulse on the cycle after the last op.

## Operation
- FSM states: IDLE, INIT, SUB, SHIFT, MIX, ADDKEY, DONE. A separate 4-bit round counter and a 1-bit latched direction `dir` complete the state.
- **IDLE:** `ld_state_o`=0 and `busy_o`=0. On `start_i`=1 the block latches `dir`, moves to INIT and loads the counter with 0 (encrypt) or NR (decrypt).
- **INIT:** `op`=ADDKEY and `round_o` shows the loaded counter value.
- **Encrypt sequence.**
  - From INIT, the counter increments on every entry to SUB.
  - Each round is SUB → SHIFT → MIX → ADDKEY.
  - When the counter equals NR, MIX is skipped: SHIFT → ADDKEY.
  - ADDKEY with counter equal to NR goes to DONE; otherwise it goes to SUB.
- **Decrypt sequence.**
  - From INIT, the counter decrements on every entry to SHIFT.
  - Each round is SHIFT → SUB → ADDKEY → MIX.
  - When the counter equals 0, ADDKEY goes directly to DONE and MIX is skipped.
- `ld_state_o`=1 in INIT, SUB, SHIFT, MIX and ADDKEY; it is 0 in IDLE and DONE.
- **DONE:** `done_o`=1 for exactly one cycle, then the FSM returns to IDLE. In DONE, `op_o` and `round_o` hold their last values.
- `start_i` is ignored in every state other than IDLE, including DONE.
- `decrypt_i` changes after acceptance have no effect.
- **Reset values, asynchronous and at any point including mid-block:**
  - FSM state IDLE, counter 0, `dir` 0.
  - Outputs: `op_o`=0, `inverse_o`=0, `round_o`=0, `busy_o`=0, `done_o`=0, `ld_state_o`=0.
  - No `done_o` pulse is issued for an aborted block.

## Timing
- Total op cycles per block = 1 (INIT) + 4·(NR−1) + 3 = 4·NR. That is 40 for NR=10, 48 for NR=12 and 56 for NR=14.
- Accept edge = cycle 0. Op cycles occupy cycles 1..4·NR. `done_o` is high in cycle 4·NR+1.
- The earliest next acceptance is cycle 4·NR+2: IDLE is reached at that edge, so `ld_input_o` can assert in that cycle.
- `op_o`, `round_o` and `inverse_o` are registered FSM decodes. `ld_input_o` is the only combinational output.

## Configuration
- `AES_CTRL_DECRYPT_EN` defined: full inverse-cipher support, as described above.
- `AES_CTRL_DECRYPT_EN` undefined:
  - `decrypt_i` is ignored and `dir` is a constant 0.
  - `inverse_o` is tied to 0.
  - The decrypt transition logic is not compiled.
  - Encrypt timing is unchanged.

## Structure
- Shared package `aes_pkg` holds:
  - the `op` encoding constants `AES_OP_ADDKEY`, `AES_OP_SUB`, `AES_OP_SHIFT` and `AES_OP_MIX`;
  - the FSM state enum;
  - the legal NR values.
- No sub-module. One FSM, one round counter and the `dir` register, in a single file.

## Test plan
- Encrypt, NR=10, start at cycle 0:
  - `op_o` sequence is ADDKEY, then (SUB, SHIFT, MIX, ADDKEY)×9, then SUB, SHIFT, ADDKEY.
  - `round_o` is 0, then 1..10.
  - `done_o` is high only in cycle 41.
- Decrypt, NR=10:
  - `op_o` sequence is ADDKEY(10), then (SHIFT, SUB, ADDKEY, MIX) with `round_o` 9..1, then SHIFT, SUB, ADDKEY(0).
  - `inverse_o`=1 throughout; `done_o` is high in cycle 41.
- `start_i` held high continuously, NR=10:
  - Blocks are accepted at cycles 0, 42 and 84.
  - `start_i` has no effect during busy or DONE.
- `rst` asserted at cycle 17 mid-encrypt:
  - All outputs go to their reset values immediately.
  - No `done_o` pulse; the next start after `rst` deasserts runs a full 40-op block.
- NR=14 encrypt: 56 op cycles, final `round_o`=14, `done_o` high in cycle 57.
- Build without `AES_CTRL_DECRYPT_EN`, `decrypt_i`=1: the sequence is identical to the encrypt case and `inverse_o`=0.

Source files
------------

// File: rtl/aes_round_ctrl_pkg.sv
// Shared definitions for the iterative AES round controller: datapath op
// encoding, FSM state enumeration and the legal round counts.
package aes_pkg;

  typedef logic [1:0] aes_op_t;

  localparam aes_op_t AES_OP_ADDKEY = 2'd0;
  localparam aes_op_t AES_OP_SUB    = 2'd1;
  localparam aes_op_t AES_OP_SHIFT  = 2'd2;
  localparam aes_op_t AES_OP_MIX    = 2'd3;

  typedef enum logic [2:0] {
    AES_ST_IDLE   = 3'd0,
    AES_ST_INIT   = 3'd1,
    AES_ST_SUB    = 3'd2,
    AES_ST_SHIFT  = 3'd3,
    AES_ST_MIX    = 3'd4,
    AES_ST_ADDKEY = 3'd5,
    AES_ST_DONE   = 3'd6
  } aes_state_e;

  localparam int AES_NR_128 = 10;
  localparam int AES_NR_192 = 12;
  localparam int AES_NR_256 = 14;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Control bus between the AES sequencer and its requester/datapath.
// master: block requester side, slave: the sequencer itself.
interface aes_round_ctrl_if;
  import aes_pkg::*;

  logic       start_i;
  logic       decrypt_i;
  logic       ld_input_o;
  logic       ld_state_o;
  aes_op_t    op_o;
  logic       inverse_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       done_o;

  modport master (
    output start_i, decrypt_i,
    input  ld_input_o, ld_state_o, op_o, inverse_o, round_o, busy_o, done_o
  );

  modport slave (
    input  start_i, decrypt_i,
    output ld_input_o, ld_state_o, op_o, inverse_o, round_o, busy_o, done_o
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Sequencer for the one-transform-per-clock AES round datapath.
// Optional feature macro: AES_CTRL_DECRYPT_EN (inverse-cipher sequencing);
// without it the direction is fixed to encrypt and inverse_o is tied low.
//
// state  | meaning
// IDLE   | waiting for start_i
// INIT   | initial AddRoundKey with the loaded round index
// SUB    | SubBytes
// SHIFT  | ShiftRows
// MIX    | MixColumns (skipped in the final round)
// ADDKEY | AddRoundKey for the current round index
// DONE   | one-cycle completion pulse, outputs hold last op/round
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NR = AES_NR_128
) (
  input logic            clk,
  input logic            rst,
  aes_round_ctrl_if.slave bus
);

  localparam logic [2:0] S_IDLE   = 3'(AES_ST_IDLE);
  localparam logic [2:0] S_INIT   = 3'(AES_ST_INIT);
  localparam logic [2:0] S_SUB    = 3'(AES_ST_SUB);
  localparam logic [2:0] S_SHIFT  = 3'(AES_ST_SHIFT);
  localparam logic [2:0] S_MIX    = 3'(AES_ST_MIX);
  localparam logic [2:0] S_ADDKEY = 3'(AES_ST_ADDKEY);
  localparam logic [2:0] S_DONE   = 3'(AES_ST_DONE);

  localparam logic [3:0] NR_C = 4'(NR);

  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       dir_q;
  aes_op_t    op_q;
  logic       busy_q;

`ifdef AES_CTRL_DECRYPT_EN
  logic dir_d;

  // Direction latch, captured only when a block is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dir_q <= 1'b0;
    else     dir_q <= dir_d;
  end
`else
  logic unused_decrypt;
  assign unused_decrypt = bus.decrypt_i;
  assign dir_q          = 1'b0;
`endif

  // Next-state and round-counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
`ifdef AES_CTRL_DECRYPT_EN
    dir_d   = dir_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_INIT;
`ifdef AES_CTRL_DECRYPT_EN
          dir_d   = bus.decrypt_i;
          cnt_d   = bus.decrypt_i ? NR_C : 4'd0;
`else
          cnt_d   = 4'd0;
`endif
        end
      end
      S_INIT: begin
`ifdef AES_CTRL_DECRYPT_EN
        if (dir_q) begin
          state_d = S_SHIFT;
          cnt_d   = cnt_q - 4'd1;
        end else
`endif
        begin
          state_d = S_SUB;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_SUB: begin
`ifdef AES_CTRL_DECRYPT_EN
        if (dir_q) state_d = S_ADDKEY;
        else
`endif
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
`ifdef AES_CTRL_DECRYPT_EN
        if (dir_q) state_d = S_SUB;
        else
`endif
        state_d = (cnt_q == NR_C) ? S_ADDKEY : S_MIX;
      end
      S_MIX: begin
`ifdef AES_CTRL_DECRYPT_EN
        if (dir_q) begin
          state_d = S_SHIFT;
          cnt_d   = cnt_q - 4'd1;
        end else
`endif
        state_d = S_ADDKEY;
      end
      S_ADDKEY: begin
`ifdef AES_CTRL_DECRYPT_EN
        if (dir_q) state_d = (cnt_q == 4'd0) ? S_DONE : S_MIX;
        else
`endif
        if (cnt_q == NR_C) begin
          state_d = S_DONE;
        end else begin
          state_d = S_SUB;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and registered output decodes; op holds through DONE/IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_q    <= AES_OP_ADDKEY;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d != S_IDLE) && (state_d != S_DONE);
      case (state_d)
        S_INIT, S_ADDKEY: op_q <= AES_OP_ADDKEY;
        S_SUB:            op_q <= AES_OP_SUB;
        S_SHIFT:          op_q <= AES_OP_SHIFT;
        S_MIX:            op_q <= AES_OP_MIX;
        default:          op_q <= op_q;
      endcase
    end
  end

  assign bus.ld_input_o = bus.start_i & (state_q == S_IDLE);
  assign bus.ld_state_o = busy_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = (state_q == S_DONE);
  assign bus.op_o       = op_q;
  assign bus.round_o    = cnt_q;
  assign bus.inverse_o  = dir_q;

endmodule
